// File: rtl/ars_mladder.sv
// K-233 Montgomery-ladder scalar multiplier (Lopez-Dahab), two digit-serial multipliers; done is a held level.
// Optional macro ARS_LADDER_CYCCNT_EN adds a saturating busy-cycle counter on port cycles.

module ARS_mult_ip #(
  parameter int M = 233,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         rdy,
  output logic [M-1:0] p
);
  localparam int K = 74;

  function automatic logic [M-1:0] red(input logic [M+D-1:0] v);
    logic [M-1:0] r;
    r = v[M-1:0];
    for (int j = 0; j < D; j++) begin
      r[j]   = r[j]   ^ v[M+j];
      r[K+j] = r[K+j] ^ v[M+j];
    end
    return r;
  endfunction

  function automatic logic [M-1:0] dmul(input logic [M-1:0] x, input logic [D-1:0] d);
    logic [M+D-1:0] t;
    t = '0;
    for (int j = 0; j < D; j++)
      if (d[j]) t = t ^ ({{D{1'b0}}, x} << j);
    return red(t);
  endfunction

  logic         run, fin;
  logic [M-1:0] acc, aa, bb;

  // LSB-first digits of b; stops as soon as the remaining digits are zero, so latency is data dependent
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      fin <= 1'b0;
      acc <= '0;
      aa  <= '0;
      bb  <= '0;
    end else if (!en) begin
      run <= 1'b0;
      fin <= 1'b0;
    end else if (!run && !fin) begin
      run <= 1'b1;
      acc <= '0;
      aa  <= a;
      bb  <= b;
    end else if (run) begin
      if (bb == '0) begin
        run <= 1'b0;
        fin <= 1'b1;
      end else begin
        acc <= acc ^ dmul(aa, bb[D-1:0]);
        aa  <= red({aa, {D{1'b0}}});
        bb  <= bb >> D;
      end
    end
  end

  assign rdy = fin;
  assign p   = acc;
endmodule

module ars_mladder #(
  parameter int NBITS = 233,
  parameter int M     = 233
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] k,
  input  logic [M-1:0]     x0,
  output logic             busy,
  output logic             done,
  output logic [M-1:0]     X1,
  output logic [M-1:0]     Z1,
  output logic [M-1:0]     X2,
  output logic [M-1:0]     Z2
`ifdef ARS_LADDER_CYCCNT_EN
  ,
  output logic [31:0]      cycles
`endif
);
  localparam int IW = $clog2(NBITS);
  localparam int K  = 74;

  function automatic logic [M-1:0] sq(input logic [M-1:0] a);
    logic [2*M-2:0] v;
    v = '0;
    for (int j = 0; j < M; j++) v[2*j] = a[j];
    for (int j = 2*M-2; j >= M; j--)
      if (v[j]) begin
        v[j-M]   = ~v[j-M];
        v[j-M+K] = ~v[j-M+K];
      end
    return v[M-1:0];
  endfunction

  typedef enum logic [2:0] {IDLE, SCAN, INIT, MUL1, MUL2, MUL3, NEXT, DONE} state_t;
  state_t state, state_n;

  logic [NBITS-1:0] kr;
  logic [IW-1:0]    i;
  logic [M-1:0]     xr, xd, zd, t1, t2, p0, p1;
  logic             m0_en, m1_en, got0, got1;
  logic [M-1:0]     a0, b0, a1, b1, prod0, prod1;
  logic             rdy0, rdy1;
  logic             bit_k, last, accept, need0, need1, fire0, fire1, stage_done;
  logic [M-1:0]     xa, za, xb, zb, r0, r1, za_n, xa_n, sq_xd, sq_zd, xd_n, sq_x0;

  assign bit_k  = kr[i];
  assign last   = (i == '0);
  assign accept = start && (state == IDLE || state == DONE);
  assign xa     = bit_k ? X1 : X2;
  assign za     = bit_k ? Z1 : Z2;
  assign xb     = bit_k ? X2 : X1;
  assign zb     = bit_k ? Z2 : Z1;
  assign r0     = got0 ? p0 : prod0;
  assign r1     = got1 ? p1 : prod1;
  assign za_n   = sq(t1 ^ t2);
  assign xa_n   = r0 ^ r1;
  assign sq_xd  = sq(xd);
  assign sq_zd  = sq(zd);
  assign xd_n   = sq(sq_xd ^ sq_zd);
  assign sq_x0  = sq(xr);

  assign need0      = (state == MUL1) || (state == MUL2) || (state == MUL3);
  assign need1      = (state == MUL1) || (state == MUL2);
  assign fire0      = m0_en && rdy0;
  assign fire1      = m1_en && rdy1;
  assign stage_done = (!need0 || got0 || fire0) && (!need1 || got1 || fire1);

  always_comb begin
    a0 = xa;
    b0 = zb;
    a1 = xb;
    b1 = za;
    case (state)
      MUL2: begin a0 = xr; b0 = za_n; a1 = t1; b1 = t2; end
      MUL3: begin a0 = sq_xd; b0 = sq_zd; end
      default: ;
    endcase
  end

  ARS_mult_ip #(.M(M)) u_m0 (.clk(clk), .rst(rst), .en(m0_en), .a(a0), .b(b0), .rdy(rdy0), .p(prod0));
  ARS_mult_ip #(.M(M)) u_m1 (.clk(clk), .rst(rst), .en(m1_en), .a(a1), .b(b1), .rdy(rdy1), .p(prod1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (bit_k) state_n = INIT; else if (last) state_n = DONE;
      INIT:    state_n = last ? DONE : MUL1;
      MUL1:    if (stage_done) state_n = MUL2;
      MUL2:    if (stage_done) state_n = MUL3;
      MUL3:    if (stage_done) state_n = NEXT;
      NEXT:    state_n = last ? DONE : MUL1;
      DONE:    if (start) state_n = SCAN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kr <= '0; i <= '0; xr <= '0; xd <= '0; zd <= '0; t1 <= '0; t2 <= '0;
      p0 <= '0; p1 <= '0; m0_en <= 1'b0; m1_en <= 1'b0; got0 <= 1'b0; got1 <= 1'b0;
      busy <= 1'b0; done <= 1'b0; X1 <= '0; Z1 <= '0; X2 <= '0; Z2 <= '0;
    end else begin
      state <= state_n;
      // en is held until rdy, then dropped; an early product waits in p0/p1 for its partner
      if (need0 && !got0) begin
        if (fire0) begin m0_en <= 1'b0; got0 <= 1'b1; p0 <= prod0; end
        else m0_en <= 1'b1;
      end
      if (need1 && !got1) begin
        if (fire1) begin m1_en <= 1'b0; got1 <= 1'b1; p1 <= prod1; end
        else m1_en <= 1'b1;
      end
      if (need0 && stage_done) begin
        got0 <= 1'b0;
        got1 <= 1'b0;
      end
      case (state)
        IDLE, DONE: if (start) begin
          kr <= k; xr <= x0; i <= IW'(NBITS-1); done <= 1'b0; busy <= 1'b1;
        end
        SCAN: if (!bit_k) begin
          if (last) begin
            X1 <= '0; Z1 <= '0; X2 <= '0; Z2 <= '0; busy <= 1'b0; done <= 1'b1;
          end else i <= i - IW'(1);
        end
        INIT: begin
          X1 <= xr; Z1 <= M'(1); X2 <= sq(sq_x0) ^ M'(1); Z2 <= sq_x0;
          if (last) begin busy <= 1'b0; done <= 1'b1; end
          else i <= i - IW'(1);
        end
        // the doubling target is untouched by the add, so latching it here keeps pre-step values
        MUL1: if (stage_done) begin t1 <= r0; t2 <= r1; xd <= xb; zd <= zb; end
        MUL2: if (stage_done) begin
          if (bit_k) begin X1 <= xa_n; Z1 <= za_n; end
          else       begin X2 <= xa_n; Z2 <= za_n; end
        end
        MUL3: if (stage_done) begin
          if (bit_k) begin X2 <= xd_n; Z2 <= r0; end
          else       begin X1 <= xd_n; Z1 <= r0; end
        end
        NEXT: begin
          if (last) begin busy <= 1'b0; done <= 1'b1; end
          else i <= i - IW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ARS_LADDER_CYCCNT_EN
  always_ff @(posedge clk) begin
    if (rst || accept) cycles <= '0;
    else if (busy && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
  end
`endif
endmodule
